truth_table_sweeper: RTL and testbench

- Synthesisable successor to the exhaustive 4-input lab bench.
- Drives all 2^N_IN input combinations onto a combinational function-under-test (FUT), holding each for DWELL clocks.
- Samples the FUT output for each vector, compares it against an expected minterm mask, and records the captured truth table, the mismatch count and the first failing vector.
- Sits between an on-board start button/controller and any single-output lab function.

---
 rtl/lab_pkg.sv | 15 +
 rtl/tts_dwell_counter.sv | 39 +++
 rtl/truth_table_sweeper.sv | 158 +++++++++++++++
 tb/tb_truth_table_sweeper.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lab_pkg.sv
// Shared types and helpers for the truth-table sweeper and its dwell counter.
package lab_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } tts_state_t;

  // Number of distinct input vectors for an n-input function.
  function automatic int unsigned vec_count(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tts_dwell_counter.sv
// Counts the clocks each vector is held; tc marks the last clock of the dwell,
// which is the clock on which the FUT output is sampled.
module tts_dwell_counter #(
  parameter int unsigned DWELL = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int unsigned CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc = (cnt_q == CW'(DWELL - 1));

  always_comb begin
    // NOTE: default assignment first so no path leaves cnt_d unassigned (no latch).
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tc ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: non-blocking assignments for flops so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustively drives every input vector onto an external single-output function,
// captures its truth table and compares it against an expected minterm mask.
module truth_table_sweeper
  import lab_pkg::*;
#(
  parameter int unsigned                     N_IN     = 4,
  parameter int unsigned                     DWELL    = 20,
  parameter logic [vec_count(N_IN)-1:0]      EXP_MASK = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic [N_IN-1:0]               stim,
  input  logic                          dut_f,
  output logic                          busy,
  output logic                          done,
  output logic                          pass,
  output logic [N_IN:0]                 err_count,
  output logic [N_IN-1:0]               first_err_vec,
  output logic                          first_err_valid,
  output logic [vec_count(N_IN)-1:0]    resp
);

  localparam int unsigned VEC = vec_count(N_IN);
  localparam int unsigned CW  = N_IN + 1;

  tts_state_t      state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pass_q, pass_d;
  logic [CW-1:0]   err_count_q, err_count_d;
  logic [N_IN-1:0] first_err_vec_q, first_err_vec_d;
  logic            first_err_valid_q, first_err_valid_d;
  logic [VEC-1:0]  resp_q, resp_d;

  logic dwell_tc;
  logic dwell_clr;
  logic in_drive;
  logic sample;
  logic last_vec;

  assign in_drive  = (state_q == DRIVE);
  assign dwell_clr = !in_drive || abort;
  // abort beats the sample update, so a sample is only taken when not aborting.
  assign sample    = in_drive && dwell_tc && !abort;
  assign last_vec  = &stim_q;

  tts_dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (dwell_clr),
    .en    (in_drive),
    .tc    (dwell_tc)
  );

  always_comb begin
    state_d           = state_q;
    stim_d            = stim_q;
    busy_d            = busy_q;
    done_d            = 1'b0;
    pass_d            = pass_q;
    err_count_d       = err_count_q;
    first_err_vec_d   = first_err_vec_q;
    first_err_valid_d = first_err_valid_q;
    resp_d            = resp_q;

    unique case (state_q)
      IDLE: begin
        stim_d = '0;
        if (start && !abort) begin
          state_d           = DRIVE;
          busy_d            = 1'b1;
          err_count_d       = '0;
          first_err_vec_d   = '0;
          first_err_valid_d = 1'b0;
          resp_d            = '0;
          pass_d            = 1'b0;
        end
      end

      DRIVE: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          stim_d  = '0;
        end else if (sample) begin
          resp_d[stim_q] = dut_f;
          if (dut_f != EXP_MASK[stim_q]) begin
            err_count_d = err_count_q + CW'(1);
            if (!first_err_valid_q) begin
              first_err_vec_d   = stim_q;
              first_err_valid_d = 1'b1;
            end
          end
          if (last_vec) begin
            // pass must reflect the final vector's compare, hence err_count_d.
            state_d = FINISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stim_d  = '0;
            pass_d  = (err_count_d == '0);
          end else begin
            stim_d = stim_q + N_IN'(1);
          end
        end
      end

      FINISH: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        stim_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      stim_q            <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      pass_q            <= 1'b0;
      err_count_q       <= '0;
      first_err_vec_q   <= '0;
      first_err_valid_q <= 1'b0;
      // NOTE: resp is a plain flop vector, not a RAM, so it is safe to reset.
      resp_q            <= '0;
    end else begin
      state_q           <= state_d;
      stim_q            <= stim_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      pass_q            <= pass_d;
      err_count_q       <= err_count_d;
      first_err_vec_q   <= first_err_vec_d;
      first_err_valid_q <= first_err_valid_d;
      resp_q            <= resp_d;
    end
  end

  assign stim            = stim_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_count       = err_count_q;
  assign first_err_vec   = first_err_vec_q;
  assign first_err_valid = first_err_valid_q;
  assign resp            = resp_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for the truth-table sweeper: a 4-input/DWELL=2 instance driven by table-based
// FUTs and a 2-input/DWELL=1 XOR instance, checked against a truth-table model.
module tb_truth_table_sweeper;

  localparam logic [15:0] EXP_A = 16'hA5C3;
  localparam logic [3:0]  EXP_B = 4'b0110;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start_a = 1'b0, abort_a = 1'b0;
  logic [3:0]  stim_a;
  logic        dut_f_a, busy_a, done_a, pass_a, first_err_valid_a;
  logic [4:0]  err_count_a;
  logic [3:0]  first_err_vec_a;
  logic [15:0] resp_a;
  logic [15:0] fut_tbl_a = 16'h0000;

  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [1:0]  stim_b;
  logic        dut_f_b, busy_b, done_b, pass_b, first_err_valid_b;
  logic [2:0]  err_count_b;
  logic [1:0]  first_err_vec_b;
  logic [3:0]  resp_b;

  assign dut_f_a = fut_tbl_a[stim_a];
  assign dut_f_b = stim_b[1] ^ stim_b[0];

  truth_table_sweeper #(.N_IN(4), .DWELL(2), .EXP_MASK(EXP_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .stim(stim_a),
    .dut_f(dut_f_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_count_a), .first_err_vec(first_err_vec_a),
    .first_err_valid(first_err_valid_a), .resp(resp_a)
  );

  truth_table_sweeper #(.N_IN(2), .DWELL(1), .EXP_MASK(EXP_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .stim(stim_b),
    .dut_f(dut_f_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_count_b), .first_err_vec(first_err_vec_b),
    .first_err_valid(first_err_valid_b), .resp(resp_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: the captured table is the FUT table over the vectors actually sampled;
  // mismatches are the positions where that table differs from EXP_A.
  task automatic model_a(input logic [15:0] tbl, input int nvec,
                         output logic [15:0] r, output int errs,
                         output int first, output bit fvalid);
    r = '0; errs = 0; first = 0; fvalid = 0;
    for (int i = 0; i < nvec; i++) begin
      r[i] = tbl[i];
      if (tbl[i] != EXP_A[i]) begin
        errs++;
        if (!fvalid) begin
          fvalid = 1;
          first  = i;
        end
      end
    end
  endtask

  task automatic check_results_a(input string tag, input logic [15:0] tbl,
                                 input int nvec, input bit aborted);
    logic [15:0] r;
    int errs, first;
    bit fvalid;
    model_a(tbl, nvec, r, errs, first, fvalid);
    check({tag, "_resp"}, resp_a, r);
    check({tag, "_err_count"}, err_count_a, errs);
    check({tag, "_first_valid"}, first_err_valid_a, fvalid);
    check({tag, "_first_vec"}, first_err_vec_a, first);
    check({tag, "_pass"}, pass_a, (!aborted && errs == 0) ? 1 : 0);
  endtask

  // Full sweep on instance A; optionally pulses start again while stim==restart_at.
  task automatic sweep_a(input logic [15:0] tbl, input int restart_at, input string tag);
    int  n;
    bit  pulsed;
    bit  got_done;
    fut_tbl_a = tbl;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    check({tag, "_busy_rise"}, busy_a, 1);
    check({tag, "_stim0"}, stim_a, 0);
    n = 0; pulsed = 0; got_done = 0;
    while (n < 200 && !got_done) begin
      if (restart_at >= 0 && !pulsed && stim_a == restart_at[3:0]) begin
        start_a = 1'b1;
        pulsed  = 1;
      end else begin
        start_a = 1'b0;
      end
      @(negedge clk);
      n++;
      got_done = done_a;
    end
    start_a = 1'b0;
    check({tag, "_latency"}, n, 32);
    check({tag, "_busy_at_done"}, busy_a, 0);
    check({tag, "_stim_at_done"}, stim_a, 0);
    check_results_a(tag, tbl, 16, 0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done_a, 0);
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, resp_a, tbl);
  endtask

  // Sweep on instance A aborted while stim==k; extra picks dwell slot 0 or the sample slot.
  task automatic abort_sweep_a(input logic [15:0] tbl, input int k, input int extra,
                               input string tag);
    int n;
    bit saw_done;
    fut_tbl_a = tbl;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (n < 200 && stim_a != k[3:0]) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_reach"}, stim_a, k);
    repeat (extra) @(negedge clk);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_stim"}, stim_a, 0);
    saw_done = done_a;
    repeat (5) begin
      @(negedge clk);
      if (done_a) saw_done = 1;
    end
    check({tag, "_no_done"}, saw_done, 0);
    check_results_a(tag, tbl, k, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] tbl;
    logic [15:0] resp_before;
    int k, n;

    repeat (2) @(negedge clk);
    check("rst_stim", stim_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_pass", pass_a, 0);
    check("rst_err", err_count_a, 0);
    check("rst_fvec", first_err_vec_a, 0);
    check("rst_fvalid", first_err_valid_a, 0);
    check("rst_resp", resp_a, 0);
    check("rst_b_busy", busy_b, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    sweep_a(EXP_A, -1, "match");
    sweep_a(EXP_A ^ 16'h0020, -1, "flip5");
    check("flip5_resp_const", resp_a, 16'hA5E3);
    sweep_a(~EXP_A, -1, "invert");
    check("invert_resp_const", resp_a, 16'h5A3C);
    sweep_a(EXP_A ^ 16'h0100, 3, "restart");

    abort_sweep_a(EXP_A ^ 16'h0044, 7, 0, "abort7");

    for (int i = 0; i < 4; i++) begin
      tbl = 16'($urandom);
      sweep_a(tbl, -1, $sformatf("rand%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      tbl = 16'($urandom);
      abort_sweep_a(tbl, int'($urandom_range(1, 15)), int'($urandom_range(0, 1)),
                    $sformatf("rabort%0d", i));
    end

    // abort and start together in IDLE: stay idle, results untouched.
    resp_before = resp_a;
    start_a = 1'b1; abort_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0; abort_a = 1'b0;
    check("idle_abort_start_busy", busy_a, 0);
    @(negedge clk);
    check("idle_abort_start_busy2", busy_a, 0);
    check("idle_abort_start_resp", resp_a, resp_before);

    // Async reset in the middle of a sweep.
    fut_tbl_a = ~EXP_A;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (n < 200 && stim_a != 4'd9) begin
      @(negedge clk);
      n++;
    end
    check("areset_reach9", stim_a, 9);
    #2 rst_n = 1'b0;
    #1;
    check("areset_stim", stim_a, 0);
    check("areset_busy", busy_a, 0);
    check("areset_done", done_a, 0);
    check("areset_err", err_count_a, 0);
    check("areset_fvalid", first_err_valid_a, 0);
    check("areset_resp", resp_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tbl = 16'($urandom);
    sweep_a(tbl, -1, "post_reset");

    // Instance B: N_IN=2, DWELL=1, XOR FUT.
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    check("b_busy_rise", busy_b, 1);
    for (int v = 0; v < 4; v++) begin
      check($sformatf("b_stim%0d", v), stim_b, v);
      check($sformatf("b_nodone%0d", v), done_b, 0);
      @(negedge clk);
    end
    check("b_done", done_b, 1);
    check("b_pass", pass_b, 1);
    check("b_err", err_count_b, 0);
    check("b_resp", resp_b, 4'b0110);
    check("b_fvalid", first_err_valid_b, 0);
    @(negedge clk);
    check("b_done_1cyc", done_b, 0);
    abort_b = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
